// File: rtl/xbar_sched_pkg.sv
// Shared encodings for the 2x2 crossbar scheduler.
// Crossbar control values, per-output owner encoding, destination encoding.
// No ports; imported by xbar_out_arb and crossbar_2x2_sched.
package xbar_sched_pkg;

  localparam logic CTRL_BAR   = 1'b0;  // in1->out1, in2->out2
  localparam logic CTRL_CROSS = 1'b1;  // in1->out2, in2->out1

  localparam logic DEST_OUT1 = 1'b0;
  localparam logic DEST_OUT2 = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IN1  = 2'b01,
    OWN_IN2  = 2'b10
  } owner_e;

endpackage

// File: rtl/xbar_out_arb.sv
// Per-output arbiter: holds the owner of one output and grants one input per cycle.
// Ports: head/locked request qualifiers from both inputs, output space, shared rr_pri in;
//        grant1/grant2, conflict (both heads competed), current owner out.
module xbar_out_arb
  import xbar_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en_i,
  input  logic   head_req1_i,
  input  logic   head_req2_i,
  input  logic   valid1_i,
  input  logic   valid2_i,
  input  logic   last1_i,
  input  logic   last2_i,
  input  logic   space_i,
  input  logic   rr_pri_i,
  output logic   grant1_o,
  output logic   grant2_o,
  output logic   conflict_o,
  output owner_e owner_o
);

  owner_e owner_q, owner_d;

  always_comb begin
    grant1_o   = 1'b0;
    grant2_o   = 1'b0;
    conflict_o = 1'b0;
    owner_d    = owner_q;

    if (en_i && space_i) begin
      case (owner_q)
        OWN_IN1: grant1_o = valid1_i;
        OWN_IN2: grant2_o = valid2_i;
        default: begin
          if (head_req1_i && head_req2_i) begin
            conflict_o = 1'b1;
            grant1_o   = !rr_pri_i;
            grant2_o   = rr_pri_i;
          end else begin
            grant1_o = head_req1_i;
            grant2_o = head_req2_i;
          end
        end
      endcase
    end

    // Lock on a non-last beat, release on the last beat; single-beat packets never lock.
    if (grant1_o) begin
      owner_d = last1_i ? OWN_NONE : OWN_IN1;
    end else if (grant2_o) begin
      owner_d = last2_i ? OWN_NONE : OWN_IN2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner_o = owner_q;

endmodule

// File: rtl/crossbar_2x2_sched.sv
// Scheduler and registered output stage for the 2x2 DW-bit crossbar.
// Ports: two input beat streams (valid/dest/last/data, combinational ready),
//        two registered output streams (valid/data/last, ready in), registered control bit.
module crossbar_2x2_sched
  import xbar_sched_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in1_valid,
  input  logic          in1_dest,
  input  logic          in1_last,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  input  logic          in2_valid,
  input  logic          in2_dest,
  input  logic          in2_last,
  input  logic [DW-1:0] in2_data,
  output logic          in2_ready,
  output logic          out1_valid,
  output logic [DW-1:0] out1_data,
  output logic          out1_last,
  input  logic          out1_ready,
  output logic          out2_valid,
  output logic [DW-1:0] out2_data,
  output logic          out2_last,
  input  logic          out2_ready,
  output logic          control
);

  owner_e own1, own2;
  logic   free1, free2;
  logic   space1, space2;
  logic   g1_o1, g2_o1, g1_o2, g2_o2;
  logic   conf1, conf2;
  logic   sel, xfer;
  logic   wr1, wr2;
  logic   [DW-1:0] sw1_data, sw2_data;
  logic   sw1_last, sw2_last;

  logic          rr_pri_q, rr_pri_d;
  logic          control_q, control_d;
  logic          out1_valid_q, out2_valid_q;
  logic [DW-1:0] out1_data_q, out2_data_q;
  logic          out1_last_q, out2_last_q;

  // An input may only start a new packet when it holds neither output.
  assign free1  = (own1 != OWN_IN1) && (own2 != OWN_IN1);
  assign free2  = (own1 != OWN_IN2) && (own2 != OWN_IN2);
  assign space1 = !out1_valid_q || out1_ready;
  assign space2 = !out2_valid_q || out2_ready;

  // Grants are suppressed while reset is held so no beat is acknowledged and lost.
  xbar_out_arb u_arb_out1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (rst_n),
    .head_req1_i(in1_valid && free1 && (in1_dest == DEST_OUT1)),
    .head_req2_i(in2_valid && free2 && (in2_dest == DEST_OUT1)),
    .valid1_i   (in1_valid),
    .valid2_i   (in2_valid),
    .last1_i    (in1_last),
    .last2_i    (in2_last),
    .space_i    (space1),
    .rr_pri_i   (rr_pri_q),
    .grant1_o   (g1_o1),
    .grant2_o   (g2_o1),
    .conflict_o (conf1),
    .owner_o    (own1)
  );

  xbar_out_arb u_arb_out2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (rst_n),
    .head_req1_i(in1_valid && free1 && (in1_dest == DEST_OUT2)),
    .head_req2_i(in2_valid && free2 && (in2_dest == DEST_OUT2)),
    .valid1_i   (in1_valid),
    .valid2_i   (in2_valid),
    .last1_i    (in1_last),
    .last2_i    (in2_last),
    .space_i    (space2),
    .rr_pri_i   (rr_pri_q),
    .grant1_o   (g1_o2),
    .grant2_o   (g2_o2),
    .conflict_o (conf2),
    .owner_o    (own2)
  );

  // Each input owns at most one output, so concurrent grants never disagree on the config.
  assign sel  = (g1_o2 || g2_o1) ? CTRL_CROSS : CTRL_BAR;
  assign xfer = g1_o1 || g2_o1 || g1_o2 || g2_o2;
  assign wr1  = g1_o1 || g2_o1;
  assign wr2  = g1_o2 || g2_o2;

  assign sw1_data = (sel == CTRL_CROSS) ? in2_data : in1_data;
  assign sw1_last = (sel == CTRL_CROSS) ? in2_last : in1_last;
  assign sw2_data = (sel == CTRL_CROSS) ? in1_data : in2_data;
  assign sw2_last = (sel == CTRL_CROSS) ? in1_last : in2_last;

  assign in1_ready = g1_o1 || g1_o2;
  assign in2_ready = g2_o1 || g2_o2;

  // Only one output can see a conflict per cycle; the loser is always the non-priority input.
  assign rr_pri_d  = (conf1 || conf2) ? !rr_pri_q : rr_pri_q;
  assign control_d = xfer ? sel : control_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_pri_q     <= 1'b0;
      control_q    <= CTRL_BAR;
      out1_valid_q <= 1'b0;
      out1_data_q  <= '0;
      out1_last_q  <= 1'b0;
      out2_valid_q <= 1'b0;
      out2_data_q  <= '0;
      out2_last_q  <= 1'b0;
    end else begin
      rr_pri_q  <= rr_pri_d;
      control_q <= control_d;
      if (wr1) begin
        out1_valid_q <= 1'b1;
        out1_data_q  <= sw1_data;
        out1_last_q  <= sw1_last;
      end else if (out1_ready) begin
        out1_valid_q <= 1'b0;
      end
      if (wr2) begin
        out2_valid_q <= 1'b1;
        out2_data_q  <= sw2_data;
        out2_last_q  <= sw2_last;
      end else if (out2_ready) begin
        out2_valid_q <= 1'b0;
      end
    end
  end

  assign out1_valid = out1_valid_q;
  assign out1_data  = out1_data_q;
  assign out1_last  = out1_last_q;
  assign out2_valid = out2_valid_q;
  assign out2_data  = out2_data_q;
  assign out2_last  = out2_last_q;
  assign control    = control_q;

endmodule

// File: tb/tb_crossbar_2x2_sched.sv
// Directed bench for crossbar_2x2_sched: reset, parallel bar transfer, round-robin,
// packet locking, output backpressure and reset in the middle of a packet.
module tb_crossbar_2x2_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in1_valid, in1_dest, in1_last, in1_ready;
  logic [3:0] in1_data;
  logic       in2_valid, in2_dest, in2_last, in2_ready;
  logic [3:0] in2_data;
  logic       out1_valid, out1_last, out1_ready;
  logic [3:0] out1_data;
  logic       out2_valid, out2_last, out2_ready;
  logic [3:0] out2_data;
  logic       control;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crossbar_2x2_sched #(.DW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_valid (in1_valid),
    .in1_dest  (in1_dest),
    .in1_last  (in1_last),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .in2_valid (in2_valid),
    .in2_dest  (in2_dest),
    .in2_last  (in2_last),
    .in2_data  (in2_data),
    .in2_ready (in2_ready),
    .out1_valid(out1_valid),
    .out1_data (out1_data),
    .out1_last (out1_last),
    .out1_ready(out1_ready),
    .out2_valid(out2_valid),
    .out2_data (out2_data),
    .out2_last (out2_last),
    .out2_ready(out2_ready),
    .control   (control)
  );

  task automatic idle_inputs();
    in1_valid = 1'b0; in1_dest = 1'b0; in1_last = 1'b0; in1_data = 4'h0;
    in2_valid = 1'b0; in2_dest = 1'b0; in2_last = 1'b0; in2_data = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out1_ready = 1'b1; out2_ready = 1'b1;
    in1_valid = 1'b1; in1_dest = 1'b0; in1_last = 1'b1; in1_data = 4'hA;
    in2_valid = 1'b1; in2_dest = 1'b1; in2_last = 1'b1; in2_data = 4'h5;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in1_ready !== 1'b0) begin errors++; $display("FAIL rst_in1_ready got %0h exp 0", in1_ready); end
    checks++; if (in2_ready !== 1'b0) begin errors++; $display("FAIL rst_in2_ready got %0h exp 0", in2_ready); end
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h%0h exp 00", out1_valid, out2_valid); end
    checks++; if (out1_data !== 4'h0 || out2_data !== 4'h0 || out1_last !== 1'b0 || out2_last !== 1'b0) begin errors++; $display("FAIL rst_out_data got %0h/%0h exp 0/0", out1_data, out2_data); end
    checks++; if (control !== 1'b0) begin errors++; $display("FAIL rst_control got %0h exp 0", control); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0 || control !== 1'b0) begin errors++; $display("FAIL idle_after_rst got v=%0h%0h c=%0h exp 00/0", out1_valid, out2_valid, control); end
  endtask

  task automatic test_parallel();
    @(negedge clk);
    in1_valid = 1'b1; in1_dest = 1'b0; in1_last = 1'b1; in1_data = 4'hA;
    in2_valid = 1'b1; in2_dest = 1'b1; in2_last = 1'b1; in2_data = 4'h5;
    #1;
    checks++; if (in1_ready !== 1'b1 || in2_ready !== 1'b1) begin errors++; $display("FAIL par_ready got %0h%0h exp 11", in1_ready, in2_ready); end
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 4'hA || out1_last !== 1'b1) begin errors++; $display("FAIL par_out1 got v%0h d%0h exp v1 dA", out1_valid, out1_data); end
    checks++; if (out2_valid !== 1'b1 || out2_data !== 4'h5 || out2_last !== 1'b1) begin errors++; $display("FAIL par_out2 got v%0h d%0h exp v1 d5", out2_valid, out2_data); end
    checks++; if (control !== 1'b0) begin errors++; $display("FAIL par_control got %0h exp 0", control); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin errors++; $display("FAIL par_drain got %0h%0h exp 00", out1_valid, out2_valid); end
    checks++; if (control !== 1'b0) begin errors++; $display("FAIL par_control_hold got %0h exp 0", control); end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in1_valid = 1'b1; in1_dest = 1'b1; in1_last = 1'b1; in1_data = 4'h3;
      in2_valid = 1'b1; in2_dest = 1'b1; in2_last = 1'b1; in2_data = 4'hC;
      #1;
      checks++; if (in1_ready !== (i % 2 == 0) || in2_ready !== (i % 2 == 1)) begin errors++; $display("FAIL rr_ready[%0d] got %0h%0h exp %0h%0h", i, in1_ready, in2_ready, (i % 2 == 0), (i % 2 == 1)); end
      @(posedge clk); #1;
      checks++; if (out2_valid !== 1'b1 || out2_data !== ((i % 2 == 0) ? 4'h3 : 4'hC)) begin errors++; $display("FAIL rr_out2[%0d] got %0h exp %0h", i, out2_data, ((i % 2 == 0) ? 4'h3 : 4'hC)); end
      checks++; if (control !== (i % 2 == 0)) begin errors++; $display("FAIL rr_control[%0d] got %0h exp %0h", i, control, (i % 2 == 0)); end
      checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL rr_out1_idle[%0d] got %0h exp 0", i, out1_valid); end
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_lock();
    // beat 1 of in1's packet to out2
    @(negedge clk);
    in1_valid = 1'b1; in1_dest = 1'b1; in1_last = 1'b0; in1_data = 4'h1;
    #1;
    checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL lock_b1_ready got %0h exp 1", in1_ready); end
    @(posedge clk); #1;
    checks++; if (out2_data !== 4'h1 || out2_last !== 1'b0 || control !== 1'b1) begin errors++; $display("FAIL lock_b1_out got d%0h l%0h c%0h exp d1 l0 c1", out2_data, out2_last, control); end
    // beat 2: dest deliberately flipped, must be ignored; in2 head arrives
    @(negedge clk);
    in1_dest = 1'b0; in1_data = 4'h2;
    in2_valid = 1'b1; in2_dest = 1'b1; in2_last = 1'b1; in2_data = 4'h9;
    #1;
    checks++; if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin errors++; $display("FAIL lock_b2_ready got %0h%0h exp 10", in1_ready, in2_ready); end
    @(posedge clk); #1;
    checks++; if (out2_data !== 4'h2 || out1_valid !== 1'b0) begin errors++; $display("FAIL lock_b2_out got d%0h o1v%0h exp d2 o1v0", out2_data, out1_valid); end
    // beat 3 (last)
    @(negedge clk);
    in1_data = 4'h3; in1_last = 1'b1;
    #1;
    checks++; if (in1_ready !== 1'b1 || in2_ready !== 1'b0) begin errors++; $display("FAIL lock_b3_ready got %0h%0h exp 10", in1_ready, in2_ready); end
    @(posedge clk); #1;
    checks++; if (out2_data !== 4'h3 || out2_last !== 1'b1) begin errors++; $display("FAIL lock_b3_out got d%0h l%0h exp d3 l1", out2_data, out2_last); end
    // in2 now wins the free output
    @(negedge clk);
    in1_valid = 1'b0;
    #1;
    checks++; if (in2_ready !== 1'b1) begin errors++; $display("FAIL lock_in2_ready got %0h exp 1", in2_ready); end
    @(posedge clk); #1;
    checks++; if (out2_data !== 4'h9 || out2_valid !== 1'b1 || control !== 1'b0) begin errors++; $display("FAIL lock_in2_out got d%0h v%0h c%0h exp d9 v1 c0", out2_data, out2_valid, control); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out1_ready = 1'b0;
    in1_valid = 1'b1; in1_dest = 1'b0; in1_last = 1'b0; in1_data = 4'h6;
    #1;
    checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %0h exp 1", in1_ready); end
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 4'h6) begin errors++; $display("FAIL bp_first_out got v%0h d%0h exp v1 d6", out1_valid, out1_data); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in1_data = 4'h7;
      #1;
      checks++; if (in1_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d] got %0h exp 0", i, in1_ready); end
      @(posedge clk); #1;
      checks++; if (out1_valid !== 1'b1 || out1_data !== 4'h6 || out1_last !== 1'b0) begin errors++; $display("FAIL bp_stall_hold[%0d] got v%0h d%0h exp v1 d6", i, out1_valid, out1_data); end
    end
    @(negedge clk);
    out1_ready = 1'b1;
    #1;
    checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got %0h exp 1", in1_ready); end
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 4'h7) begin errors++; $display("FAIL bp_resume_out got v%0h d%0h exp v1 d7", out1_valid, out1_data); end
    @(negedge clk);
    in1_data = 4'h8; in1_last = 1'b1;
    #1;
    checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL bp_last_ready got %0h exp 1", in1_ready); end
    @(posedge clk); #1;
    checks++; if (out1_data !== 4'h8 || out1_last !== 1'b1 || control !== 1'b0) begin errors++; $display("FAIL bp_last_out got d%0h l%0h c%0h exp d8 l1 c0", out1_data, out1_last, control); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0h exp 0", out1_valid); end
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    out1_ready = 1'b0;
    in1_valid = 1'b1; in1_dest = 1'b0; in1_last = 1'b0; in1_data = 4'h4;
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 4'h4) begin errors++; $display("FAIL mid_setup got v%0h d%0h exp v1 d4", out1_valid, out1_data); end
    @(negedge clk);
    in1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out1_valid !== 1'b0 || out1_data !== 4'h0 || out2_valid !== 1'b0) begin errors++; $display("FAIL mid_async_clear got v%0h d%0h exp v0 d0", out1_valid, out1_data); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out1_ready = 1'b1;
    in2_valid = 1'b1; in2_dest = 1'b0; in2_last = 1'b1; in2_data = 4'hE;
    #1;
    checks++; if (in2_ready !== 1'b1) begin errors++; $display("FAIL mid_in2_ready got %0h exp 1", in2_ready); end
    @(posedge clk); #1;
    checks++; if (out1_valid !== 1'b1 || out1_data !== 4'hE || control !== 1'b1) begin errors++; $display("FAIL mid_in2_out got v%0h d%0h c%0h exp v1 dE c1", out1_valid, out1_data, control); end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    out1_ready = 1'b1;
    out2_ready = 1'b1;
    test_reset();
    test_parallel();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossbar_2x2_sched.md
Name: crossbar_2x2_sched

Overview:
- Scheduler and output stage for the team's 2x2 4-bit crossbar.
- Accepts packets on two input ports. Each packet carries a destination bit and a last flag.
- Arbitrates each output round-robin, holds a path locked until the packet's last beat, and drives the single crossbar control bit.
- Feeds registered valid/ready outputs toward the downstream lab logic.

Parameters:
- DW, 4, data width per port (the crossbar lane width).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in1_valid  input  1  input 1 has a beat.
- in1_dest  input  1  destination on the head beat: 0=out1, 1=out2. Ignored on non-head beats.
- in1_last  input  1  final beat of the packet.
- in1_data  input  DW  payload.
- in1_ready  output  1  beat accepted this cycle (combinational).
- in2_valid, in2_dest, in2_last, in2_data, in2_ready: same as input 1, for input 2.
- out1_valid  output  1  out1 register holds a beat.
- out1_data  output  DW  registered payload.
- out1_last  output  1  registered last flag.
- out1_ready  input  1  downstream accepts out1.
- out2_valid, out2_data, out2_last, out2_ready: same as out1, for out2.
- control  output  1  registered crossbar configuration of the most recent transfer. 0=bar (in1->out1, in2->out2), 1=cross (in1->out2, in2->out1).

Behaviour:
- Reset: out*_valid=0, out*_data=0, out*_last=0, control=0, both owner registers NONE, rr_pri=0.
  - rst_n low mid-packet discards all locks and buffered beats immediately.
- Per-output owner register: NONE / IN1 / IN2. Each input owns at most one output at a time.
  - Any set of simultaneous transfers is therefore always bar-consistent or cross-consistent.
- Output register space: space_Y = !outY_valid | outY_ready.
- Head request: input X requests output Y when inX_valid=1, X owns no output, inX_dest=Y, and owner_Y=NONE.
- Locked request: input X is granted output Y when owner_Y=X, inX_valid=1 and space_Y=1.
- Arbitration for a free output Y with space_Y=1:
  - Single requester: it is granted.
  - Both inputs requesting: rr_pri=0 grants in1, rr_pri=1 grants in2.
  - After any conflicted grant, rr_pri points to the loser.
  - An uncontested grant leaves rr_pri unchanged.
- Grant effects in the same cycle:
  - inX_ready=1.
  - Beat is written into outY on the next edge (latency 1 cycle).
  - owner_Y is set to X if inX_last=0.
  - owner_Y is cleared on the edge that accepts a beat with last=1 from the owner.
  - A single-beat packet never sets owner.
- Parallel transfers: both inputs may transfer in one cycle (different outputs, consistent config).
- Config and control:
  - Internal crossbar select = configuration of this cycle's grants.
  - control register loads that configuration on any transfer and holds when idle.
- Output register:
  - outY_valid clears when outY_ready=1 and no new beat is written.
  - Simultaneous drain and write keeps valid=1 with the new data.
  - outY_data/outY_last remain stable while valid=1 and ready=0.
- inX_ready is never 1 while inX_valid=0 (ready = grant only).
- Blocked input (output owned by the other input, or no space): ready=0. The input must hold its beat.

Decomposition:
- Package xbar_sched_pkg:
  - CTRL_BAR=1'b0, CTRL_CROSS=1'b1.
  - Owner encoding OWN_NONE=2'b00, OWN_IN1=2'b01, OWN_IN2=2'b10.
  - DEST_OUT1=1'b0, DEST_OUT2=1'b1.
- Sub-module xbar_out_arb, instantiated twice, once per output:
  - Holds owner_Y and produces grant1/grant2.
  - rr_pri is shared at top level.
- Top level holds: the combinational 2x2 DW-bit switch driven by the computed select, the output registers, rr_pri, and control.

Test Plan:
- Reset then idle: all outputs 0, control=0. Hold rst_n low with valid inputs -> no ready, no out valid.
- in1 dest0 data 0xA last1, in2 dest1 data 0x5 last1, same cycle -> both ready. Next cycle out1=0xA, out2=0x5, control=0.
- Both dest1, single-beat, data 0x3/0xC, repeated 4 cycles, outputs always ready -> out2 sequence in1,in2,in1,in2 (0x3,0xC,0x3,0xC). control alternates 1,0,1,0 (in1->out2 is cross, in2->out2 is bar).
- in1 3-beat packet to out2 (0x1,0x2,0x3 last); in2 head to out2 arrives on beat 2 -> in2_ready=0 until in1 last accepted. Then in2 is granted next cycle. Out2 order 1,2,3,then in2 data.
- out1_ready=0 with out1_valid=1, in1 streaming to out1 -> in1_ready=0 and out1_data held stable. Release ready -> one beat per cycle resumes with no loss or duplication.
- Assert rst_n low mid-packet (owner_out1=IN1) -> owners NONE and out valids 0 asynchronously. After release, in2 head to out1 is granted immediately.
